// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: routes icache/dcache word-level misses and writebacks onto
// the single RAM port. One transfer is in flight at a time. dcache wins
// arbitration unless it has already taken STREAK_LIMIT grants back to back
// while icache was waiting.
module cache_mem_arbiter #(
  parameter int STREAK_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, D_XFER, I_XFER} state_t;

  localparam logic [1:0]       RS_ACCESS = 2'd2;
  localparam logic [1:0]       RS_ERROR  = 2'd3;
  localparam logic [CNT_W-1:0] LIMIT     = CNT_W'(STREAK_LIMIT);

  state_t           state, next;
  logic [CNT_W-1:0] dstreak;
  logic             dreq;
  logic             d_done, i_done, ram_err;

  assign dreq = dREN | dWEN;

  // Next-state and all outputs; RAM is only driven while a transfer is live
  // and its requester still holds its enable.
  always_comb begin
    next     = state;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    d_done   = 1'b0;
    i_done   = 1'b0;
    ram_err  = 1'b0;
    case (state)
      IDLE: begin
        if (dreq && (!iREN || dstreak < LIMIT)) next = D_XFER;
        else if (iREN)                           next = I_XFER;
      end
      D_XFER: begin
        if (!dreq) begin
          next = IDLE;  // abort: requester withdrew
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          if (dWEN) ramWEN = 1'b1;
          else      ramREN = 1'b1;
          if (ramstate == RS_ACCESS) begin
            dwait  = 1'b0;
            dload  = ramload;
            d_done = 1'b1;
            next   = IDLE;
          end else if (ramstate == RS_ERROR) begin
            ram_err = 1'b1;
            next    = IDLE;  // requester gets re-arbitrated
          end
        end
      end
      I_XFER: begin
        if (!iREN) begin
          next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == RS_ACCESS) begin
            iwait  = 1'b0;
            iload  = ramload;
            i_done = 1'b1;
            next   = IDLE;
          end else if (ramstate == RS_ERROR) begin
            ram_err = 1'b1;
            next    = IDLE;
          end
        end
      end
      default: next = IDLE;
    endcase
  end

  // State, sticky error and the dcache streak counter.
  always_ff @(posedge clk) begin
    if (RST) begin
      state   <= IDLE;
      dstreak <= '0;
      err     <= 1'b0;
    end else begin
      state <= next;
      if (ram_err) err <= 1'b1;
      if (!iREN || i_done)                dstreak <= '0;
      else if (d_done && dstreak < LIMIT) dstreak <= dstreak + 1'b1;
    end
  end

endmodule
